// File: rtl/gpio_irq_controller.sv
// ============================================================================
// Module   : gpio_irq_controller
// Function : GPIO edge-enable config, pending latch, round-robin IRQ req/ack
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_irq_controller #(
    parameter int WIDTH = 16,
    parameter int ID_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  edge_in,
    output logic [WIDTH-1:0]  rising_edge,
    output logic [WIDTH-1:0]  falling_edge,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [1:0]        cfg_addr,
    input  logic [WIDTH-1:0]  cfg_wdata,
    output logic [WIDTH-1:0]  cfg_rdata,
    output logic              irq_req,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ack
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    localparam logic [1:0] c_ADDR_RISE = 2'd0;
    localparam logic [1:0] c_ADDR_FALL = 2'd1;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_PEND = 2'd3;

    localparam logic [WIDTH-1:0] c_ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [WIDTH-1:0]  r_rise;
    logic [WIDTH-1:0]  r_fall;
    logic [WIDTH-1:0]  r_mask;
    logic [WIDTH-1:0]  r_pend;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_irq_id;
    logic [WIDTH-1:0]  r_rdata;

    logic [WIDTH-1:0]  w_eligible;
    logic              w_any;
    logic [ID_W-1:0]   w_sel;
    logic [ID_W:0]     w_sum;
    logic              w_req;
    logic              w_load;
    logic              w_ack;
    logic [WIDTH-1:0]  w_w1c;
    logic [WIDTH-1:0]  w_ack_clr;

    assign w_eligible = r_pend & r_mask;
    assign w_any      = |w_eligible;

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        w_sel = '0;
        w_sum = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (ID_W + 1)'(i);
            if (w_sum >= (ID_W + 1)'(WIDTH))
                w_sum = w_sum - (ID_W + 1)'(WIDTH);
            if (w_eligible[w_sum[ID_W-1:0]])
                w_sel = w_sum[ID_W-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // FSM next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_any) w_next_state = c_ST_REQ;
            c_ST_REQ:  if (irq_ack) w_next_state = c_ST_GAP;
            c_ST_GAP:  w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_req  = (r_state == c_ST_REQ);
        w_load = (r_state == c_ST_IDLE) && w_any;
        w_ack  = (r_state == c_ST_REQ) && irq_ack;
    end

    assign w_w1c     = (cfg_we && cfg_addr == c_ADDR_PEND) ? cfg_wdata : '0;
    assign w_ack_clr = w_ack ? (c_ONE_HOT0 << r_irq_id) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rise   <= '0;
            r_fall   <= '0;
            r_mask   <= '0;
            r_pend   <= '0;
            r_ptr    <= '0;
            r_irq_id <= '0;
            r_rdata  <= '0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    c_ADDR_RISE: r_rise <= cfg_wdata;
                    c_ADDR_FALL: r_fall <= cfg_wdata;
                    c_ADDR_MASK: r_mask <= cfg_wdata;
                    default:     ;
                endcase
            end
            // New edges always win over W1C and ack clears.
            r_pend <= (r_pend & ~(w_w1c | w_ack_clr)) | edge_in;
            if (cfg_re) begin
                case (cfg_addr)
                    c_ADDR_RISE: r_rdata <= r_rise;
                    c_ADDR_FALL: r_rdata <= r_fall;
                    c_ADDR_MASK: r_rdata <= r_mask;
                    default:     r_rdata <= r_pend;
                endcase
            end
            if (w_load)
                r_irq_id <= w_sel;
            if (w_ack)
                r_ptr <= (r_irq_id == ID_W'(WIDTH - 1)) ? '0 : r_irq_id + 1'b1;
        end
    end

    assign rising_edge  = r_rise;
    assign falling_edge = r_fall;
    assign cfg_rdata    = r_rdata;
    assign irq_req      = w_req;
    assign irq_id       = r_irq_id;

endmodule

`default_nettype wire

// File: tb/tb_gpio_irq_controller.sv
// ============================================================================
// Module   : tb_gpio_irq_controller
// Function : directed self-checking bench for gpio_irq_controller
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpio_irq_controller;

    localparam int WIDTH = 16;
    localparam int ID_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  edge_in;
    logic [WIDTH-1:0]  rising_edge;
    logic [WIDTH-1:0]  falling_edge;
    logic              cfg_we;
    logic              cfg_re;
    logic [1:0]        cfg_addr;
    logic [WIDTH-1:0]  cfg_wdata;
    logic [WIDTH-1:0]  cfg_rdata;
    logic              irq_req;
    logic [ID_W-1:0]   irq_id;
    logic              irq_ack;

    int errors = 0;
    int checks = 0;

    gpio_irq_controller #(.WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .edge_in      (edge_in),
        .rising_edge  (rising_edge),
        .falling_edge (falling_edge),
        .cfg_we       (cfg_we),
        .cfg_re       (cfg_re),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata),
        .irq_req      (irq_req),
        .irq_id       (irq_id),
        .irq_ack      (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [WIDTH-1:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic cfg_read(input logic [1:0] addr, input logic [WIDTH-1:0] exp, input string tag);
        cfg_re = 1'b1; cfg_addr = addr;
        tick();
        cfg_re = 1'b0;
        chk(tag, cfg_rdata, exp);
    endtask

    task automatic pulse(input logic [WIDTH-1:0] bits);
        edge_in = bits;
        tick();
        edge_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Waits (bounded) for a request, checks its id, acks it and checks the gap.
    task automatic serve(input logic [ID_W-1:0] id, input string tag);
        int n = 0;
        while (irq_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, irq_req, 1);
        chk({tag, "_id"}, irq_id, id);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk({tag, "_drop"}, irq_req, 0);
        tick();
        chk({tag, "_gap"}, irq_req, 0);
    endtask

    initial begin
        reset = 1'b0; edge_in = '0; cfg_we = 1'b0; cfg_re = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; irq_ack = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            edge_in   = WIDTH'($urandom);
            cfg_we    = 1'($urandom);
            cfg_re    = 1'($urandom);
            cfg_addr  = 2'($urandom);
            cfg_wdata = WIDTH'($urandom);
            irq_ack   = 1'($urandom);
            tick();
        end
        chk("rst_rise", rising_edge, 0);
        chk("rst_fall", falling_edge, 0);
        chk("rst_rdata", cfg_rdata, 0);
        chk("rst_req", irq_req, 0);
        chk("rst_id", irq_id, 0);
        edge_in = '0; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; irq_ack = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("idle_no_req", irq_req, 0);
        cfg_read(2'd3, 16'h0000, "rst_pend");

        // Config path
        cfg_write(2'd0, 16'h00F0);
        chk("rise_out", rising_edge, 16'h00F0);
        cfg_write(2'd1, 16'h0F00);
        chk("fall_out", falling_edge, 16'h0F00);
        cfg_read(2'd0, 16'h00F0, "rd_rise");
        cfg_read(2'd1, 16'h0F00, "rd_fall");

        // Single IRQ: request appears exactly two edges after the pulse edge
        cfg_write(2'd2, 16'h0004);
        pulse(16'h0004);
        chk("single_req_k", irq_req, 0);
        tick();
        chk("single_req_k1", irq_req, 1);
        chk("single_id", irq_id, 2);
        tick();
        chk("single_hold", irq_req, 1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("single_drop", irq_req, 0);
        cfg_read(2'd3, 16'h0000, "single_pend");
        for (int i = 0; i < 5; i++) tick();
        chk("single_no_more", irq_req, 0);

        // Round-robin from a fresh pointer
        do_reset();
        cfg_write(2'd2, 16'hFFFF);
        pulse(16'h0222);
        serve(4'd1, "rr1");
        serve(4'd5, "rr5");
        serve(4'd9, "rr9");
        pulse(16'h1002);
        serve(4'd12, "rr12");
        serve(4'd1, "rr1b");

        // W1C colliding with a new edge: the set wins
        cfg_write(2'd2, 16'h0000);
        pulse(16'h0008);
        edge_in = 16'h0008;
        cfg_write(2'd3, 16'h0008);
        edge_in = '0;
        cfg_read(2'd3, 16'h0008, "w1c_coll");
        cfg_write(2'd3, 16'h0008);
        cfg_read(2'd3, 16'h0000, "w1c_clear");

        // Ack colliding with a new edge: the source is re-requested after the gap
        cfg_write(2'd2, 16'h0008);
        pulse(16'h0008);
        tick();
        chk("ackc_req", irq_req, 1);
        chk("ackc_id", irq_id, 3);
        irq_ack = 1'b1; edge_in = 16'h0008;
        tick();
        irq_ack = 1'b0; edge_in = '0;
        chk("ackc_drop", irq_req, 0);
        cfg_read(2'd3, 16'h0008, "ackc_pend");
        chk("ackc_gap", irq_req, 0);
        tick();
        chk("ackc_rereq", irq_req, 1);
        chk("ackc_reid", irq_id, 3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        cfg_read(2'd3, 16'h0000, "ackc_done");

        // Masked pending source, then in-flight changes do not withdraw the request
        cfg_write(2'd2, 16'h0000);
        pulse(16'h0080);
        for (int i = 0; i < 4; i++) tick();
        chk("mask_no_req", irq_req, 0);
        cfg_read(2'd3, 16'h0080, "mask_pend");
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        cfg_read(2'd3, 16'h0080, "stray_ack");
        cfg_write(2'd2, 16'h0080);
        chk("unmask_k", irq_req, 0);
        tick();
        chk("unmask_req", irq_req, 1);
        chk("unmask_id", irq_id, 7);
        cfg_write(2'd2, 16'h0000);
        chk("inflt_mask", irq_req, 1);
        cfg_write(2'd3, 16'h0080);
        chk("inflt_w1c", irq_req, 1);
        chk("inflt_id", irq_id, 7);
        cfg_read(2'd3, 16'h0000, "inflt_pend");
        chk("inflt_hold", irq_req, 1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("inflt_drop", irq_req, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("inflt_quiet", irq_req, 0);

        // Asynchronous reset mid-handshake loses the ack
        cfg_write(2'd2, 16'hFFFF);
        pulse(16'h0010);
        tick();
        chk("mid_req", irq_req, 1);
        chk("mid_id", irq_id, 4);
        irq_ack = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_async_req", irq_req, 0);
        chk("mid_async_id", irq_id, 0);
        tick();
        reset = 1'b1;
        irq_ack = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_no_rereq", irq_req, 0);
        cfg_read(2'd2, 16'h0000, "mid_mask");
        cfg_read(2'd3, 16'h0000, "mid_pend");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_irq_controller.md
# gpio_irq_controller

Interrupt controller for the GPIO edge-detection path. It owns the per-pin rising/falling edge-enable registers that configure the edge detector, and latches the detector's per-pin edge pulses into a pending register. It schedules masked pending sources to the CPU one at a time through a round-robin arbiter and a req/ack handshake. Software configures the block and reads or clears it through a small register port.

## Interface
Parameters:
- WIDTH, 16: number of GPIO pins / interrupt sources.
- ID_W, 4: width of irq_id; must satisfy 2^ID_W >= WIDTH.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-low.
- edge_in  input  WIDTH  per-pin edge pulses from the edge detector, sampled on every posedge clk.
- rising_edge  output  WIDTH  rising-edge enable flags to the edge detector; equals register RISE.
- falling_edge  output  WIDTH  falling-edge enable flags to the edge detector; equals register FALL.
- cfg_we  input  1  register write strobe.
- cfg_re  input  1  register read strobe.
- cfg_addr  input  2  register select: 0 RISE, 1 FALL, 2 MASK, 3 PENDING.
- cfg_wdata  input  WIDTH  write data.
- cfg_rdata  output  WIDTH  registered read data.
- irq_req  output  1  interrupt request to the CPU.
- irq_id  output  ID_W  index of the requesting source; stable while irq_req=1.
- irq_ack  input  1  CPU acknowledge; only meaningful while irq_req=1.

## Operation
- Reset values: RISE, FALL, MASK and PENDING are 0. irq_req=0, irq_id=0, cfg_rdata=0. The round-robin pointer is 0. The FSM is in IDLE.
- Writes: cfg_we with address 0/1/2 loads RISE/FALL/MASK with cfg_wdata. Address 3 is write-1-to-clear on PENDING (bits where cfg_wdata=1 are cleared).
- Reads: cfg_re loads cfg_rdata with the selected register on the next edge; otherwise cfg_rdata holds its value. A read of PENDING returns the value before any same-cycle update.
- PENDING update, per bit, per cycle:
  - next = (cur & ~clr) | edge_in.
  - clr = W1C bit | (ack-clear of the in-flight id).
  - A set always wins over a clear in the same cycle.
- Edges are latched into PENDING regardless of MASK. MASK gates only arbitration.
- FSM:
  - IDLE: let eligible = PENDING & MASK. If eligible is nonzero, select the first set bit searching upward from the pointer, wrapping at WIDTH-1 to 0. Load irq_id with it, set irq_req=1, go to REQ. If eligible is zero, stay in IDLE.
  - REQ: hold irq_req and irq_id. On irq_ack=1: clear PENDING[irq_id], set the pointer to (irq_id+1) mod WIDTH, drop irq_req, go to GAP.
  - GAP: one cycle with irq_req=0, then go to IDLE.
- In REQ, changes to MASK or PENDING (including a W1C of the in-flight bit) do not withdraw the request. The ack then clears nothing extra.
- irq_ack outside REQ is ignored.

## Timing
- Edge pulse sampled at edge k: PENDING bit is visible after k. irq_req rises after edge k+1, provided the FSM is in IDLE and the bit is masked-in.
- Ack sampled at edge m: irq_req=0 and the PENDING bit is cleared after m. GAP spans cycle m+1. The earliest next irq_req is after edge m+2.
- RISE/FALL writes reach rising_edge/falling_edge after the write edge, with no extra delay.
- cfg_rdata has one-cycle read latency.
- Reset asserted mid-handshake returns immediately to reset values. An ack that is pending at that moment is lost, and the source is not re-requested unless a new edge occurs.
- Throughput: at most one interrupt every 3 cycles (req, ack, gap).

## Test plan
- Reset: hold reset=0 with random inputs -> all outputs 0. After release with no edges, irq_req stays 0 indefinitely.
- Config path: write RISE=16'h00F0 and FALL=16'h0F00 -> rising_edge=16'h00F0 and falling_edge=16'h0F00 the next cycle. A read of addr 0 returns 16'h00F0 one cycle after cfg_re.
- Single IRQ: MASK=16'h0004, pulse edge_in[2] -> irq_req=1 and irq_id=2 two edges later. Ack -> irq_req=0 and PENDING=0. No further request.
- Round-robin: MASK=16'hFFFF, pulse bits 1, 5 and 9 simultaneously -> served in order 1, 5, 9. After serving 9, pulse bits 1 and 12 together -> 12 is served before 1.
- Collisions:
  - W1C of bit 3 in the same cycle as an edge_in[3] pulse -> PENDING[3] stays 1.
  - Ack of id 3 in the same cycle as an edge_in[3] pulse -> PENDING[3] stays 1, and id 3 is requested again after GAP.
- Masking/in-flight: with PENDING[7]=1 and MASK[7]=0 -> no request. While in REQ for id 7, clear MASK and W1C PENDING -> irq_req is held until ack. After ack, irq_req returns to 0.
